// File: rtl/apb_wr_demux.sv
// apb_wr_demux: APB write-side register bank.
// Decodes each APB address to one of NUM_REGS word registers and commits
// byte-strobed write data there. Decode errors complete with pslverr.
// Optional feature macro: APB_WR_WAIT_EN. When it is defined, WAIT_CYCLES
// wait states are inserted per transfer. When it is undefined, the bank is
// zero-wait and pready is high in every ACCESS cycle.
`timescale 1ns/1ps

module apb_wr_demux #(
    parameter int                    NUM_REGS    = 4,
    parameter int                    DATAWIDTH   = 32,
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    SEL_WIDTH   = $clog2(NUM_REGS),
    parameter int                    WAIT_CYCLES = 2,
    parameter logic [DATAWIDTH-1:0]  RESET_VAL   = '0
) (
    input  logic                                 pclk,
    input  logic                                 presetn,
    input  logic                                 psel,
    input  logic                                 penable,
    input  logic                                 pwrite,
    input  logic [ADDR_WIDTH-1:0]                paddr,
    input  logic [DATAWIDTH-1:0]                 pwdata,
    input  logic [DATAWIDTH/8-1:0]               pstrb,
    output logic                                 pready,
    output logic                                 pslverr,
    output logic [NUM_REGS-1:0][DATAWIDTH-1:0]   reg_q,
    output logic [NUM_REGS-1:0]                  wr_pulse
);

    localparam int STRB_W = DATAWIDTH / 8;
    localparam int OFS    = $clog2(STRB_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                                 state_q, state_d;
    logic [SEL_WIDTH-1:0]                   idx_q, idx_d;
    logic                                   wr_q, wr_d;
    logic [DATAWIDTH-1:0]                   wdata_q, wdata_d;
    logic [STRB_W-1:0]                      strb_q, strb_d;
    logic                                   err_q, err_d;
    logic [NUM_REGS-1:0][DATAWIDTH-1:0]     reg_d;
    logic [NUM_REGS-1:0]                    wr_pulse_q, wr_pulse_d;

    logic [SEL_WIDTH-1:0]                   dec_idx;
    logic                                   dec_err;

`ifdef APB_WR_WAIT_EN
    localparam int WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    logic [WCNT_W-1:0]                      wcnt_q, wcnt_d;

    // The transfer completes once the wait counter has drained.
    assign pready = (state_q == ACCESS) && (wcnt_q == '0);
`else
    // Zero-wait: every ACCESS cycle completes the transfer.
    assign pready = (state_q == ACCESS);
`endif

    // Errors are only reported alongside pready, from registered state.
    assign pslverr  = pready && err_q;
    assign wr_pulse = wr_pulse_q;

    // Address decode: register index plus misalignment / range / upper-bit checks.
    always_comb begin
        dec_err = 1'b0;
        dec_idx = paddr[OFS +: SEL_WIDTH];
        for (int i = 0; i < OFS; i++) begin
            if (paddr[i]) dec_err = 1'b1;
        end
        for (int i = OFS + SEL_WIDTH; i < ADDR_WIDTH; i++) begin
            if (paddr[i]) dec_err = 1'b1;
        end
        if (int'(dec_idx) >= NUM_REGS) dec_err = 1'b1;
    end

    // Next-state, transfer capture and write-commit logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        err_d      = err_q;
        reg_d      = reg_q;
        wr_pulse_d = '0;
`ifdef APB_WR_WAIT_EN
        wcnt_d     = wcnt_q;
`endif

        case (state_q)
            IDLE: begin
                // An enable without a preceding setup cycle is ignored.
                if (psel && !penable) state_d = SETUP;
            end

            SETUP: begin
                idx_d   = dec_idx;
                wr_d    = pwrite;
                wdata_d = pwdata;
                strb_d  = pstrb;
                err_d   = dec_err;
`ifdef APB_WR_WAIT_EN
                wcnt_d  = WCNT_W'(WAIT_CYCLES);
`endif
                state_d = ACCESS;
            end

            ACCESS: begin
                if (pready) begin
                    // Completion has priority: pready is already visible on
                    // the bus, so the transfer must take effect.
                    state_d = IDLE;
                    if (wr_q && !err_q) begin
                        wr_pulse_d[idx_q] = 1'b1;
                        for (int b = 0; b < STRB_W; b++) begin
                            if (strb_q[b]) reg_d[idx_q][b*8 +: 8] = wdata_q[b*8 +: 8];
                        end
                    end
                end else if (!psel) begin
                    // Master abandoned the transfer during the wait states.
                    state_d = IDLE;
                end else begin
`ifdef APB_WR_WAIT_EN
                    wcnt_d = wcnt_q - WCNT_W'(1);
`endif
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State, transfer-capture, register-bank and pulse flops.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
            err_q      <= 1'b0;
            // NOTE: the register bank is reset flop by flop because software
            // expects a defined value before the first write; it is not a RAM.
            reg_q      <= {NUM_REGS{RESET_VAL}};
            wr_pulse_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            err_q      <= err_d;
            reg_q      <= reg_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

`ifdef APB_WR_WAIT_EN
    // Wait-state counter.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) wcnt_q <= '0;
        else          wcnt_q <= wcnt_d;
    end
`endif

endmodule

// File: tb/tb_apb_wr_demux.sv
// tb_apb_wr_demux: directed, table-driven bench for apb_wr_demux
// (NUM_REGS=4, DATAWIDTH=32). Expected latency follows APB_WR_WAIT_EN.
`timescale 1ns/1ps

module tb_apb_wr_demux;

`ifdef APB_WR_WAIT_EN
    localparam int EXP_LAT = 2 + 2;
`else
    localparam int EXP_LAT = 2;
`endif

    logic              pclk;
    logic              presetn;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [11:0]       paddr;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic              pready;
    logic              pslverr;
    logic [3:0][31:0]  reg_q;
    logic [3:0]        wr_pulse;

    int n_cmp  = 0;
    int n_fail = 0;

    apb_wr_demux #(
        .NUM_REGS    (4),
        .DATAWIDTH   (32),
        .ADDR_WIDTH  (12),
        .WAIT_CYCLES (2),
        .RESET_VAL   (32'h0)
    ) dut (
        .pclk     (pclk),
        .presetn  (presetn),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .pready   (pready),
        .pslverr  (pslverr),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        wr;
        logic        exp_err;
        logic [3:0]  exp_pulse;
        int          chk_idx;
        logic [31:0] exp_reg;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Runs one transfer starting at a negedge; returns at the negedge after
    // the completing edge with psel dropped. lat = cycle (SETUP state = 1)
    // in which pready was seen, 0 if it never came.
    task automatic xfer(input logic [11:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic wr,
                        output int lat, output logic err, output logic [3:0] pulse);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        err  = 1'b0;
        psel = 1'b1; penable = 1'b0;
        paddr = addr; pwdata = data; pstrb = strb; pwrite = wr;
        @(negedge pclk);
        penable = 1'b1;
        check("setup_no_ready", {63'd0, pready}, 64'd0);
        for (int c = 2; c <= 20 && !seen; c++) begin
            @(negedge pclk);
            if (pready) begin
                seen = 1'b1;
                lat  = c;
                err  = pslverr;
            end else begin
                check("err_without_ready", {63'd0, pslverr}, 64'd0);
            end
        end
        @(negedge pclk);
        pulse   = wr_pulse;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    vec_t        vecs[12];
    int          lat;
    logic        err;
    logic [3:0]  pulse;

    initial begin
        vecs[0]  = '{12'h008, 32'hDEADBEEF, 4'hF,    1'b1, 1'b0, 4'b0100, 2, 32'hDEADBEEF};
        vecs[1]  = '{12'h004, 32'h11223344, 4'hF,    1'b1, 1'b0, 4'b0010, 1, 32'h11223344};
        vecs[2]  = '{12'h004, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0, 4'b0010, 1, 32'h11BB33DD};
        vecs[3]  = '{12'h010, 32'hFFFFFFFF, 4'hF,    1'b1, 1'b1, 4'b0000, 0, 32'h00000000};
        vecs[4]  = '{12'h006, 32'hFFFFFFFF, 4'hF,    1'b1, 1'b1, 4'b0000, 1, 32'h11BB33DD};
        vecs[5]  = '{12'h000, 32'hCAFEF00D, 4'hF,    1'b1, 1'b0, 4'b0001, 0, 32'hCAFEF00D};
        vecs[6]  = '{12'h00C, 32'h01234567, 4'b1000, 1'b1, 1'b0, 4'b1000, 3, 32'h01000000};
        vecs[7]  = '{12'h00C, 32'hFFFFFFFF, 4'b0000, 1'b1, 1'b0, 4'b1000, 3, 32'h01000000};
        vecs[8]  = '{12'h000, 32'h12345678, 4'hF,    1'b0, 1'b0, 4'b0000, 0, 32'hCAFEF00D};
        vecs[9]  = '{12'h801, 32'h12345678, 4'hF,    1'b0, 1'b1, 4'b0000, 2, 32'hDEADBEEF};
        vecs[10] = '{12'h008, 32'h00000000, 4'b0010, 1'b1, 1'b0, 4'b0100, 2, 32'hDEAD00EF};
        vecs[11] = '{12'hFFC, 32'h00000000, 4'hF,    1'b1, 1'b1, 4'b0000, 3, 32'h01000000};

        presetn = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(negedge pclk);
        check("rst_pready",   {63'd0, pready},   64'd0);
        check("rst_pslverr",  {63'd0, pslverr},  64'd0);
        check("rst_wr_pulse", {60'd0, wr_pulse}, 64'd0);
        for (int r = 0; r < 4; r++) check($sformatf("rst_reg%0d", r), {32'd0, reg_q[r]}, 64'd0);
        presetn = 1'b1;
        @(negedge pclk);

        // Table: consecutive calls present each new setup in the cycle after pready.
        for (int v = 0; v < 12; v++) begin
            xfer(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].wr, lat, err, pulse);
            check($sformatf("v%0d_latency", v), 64'(lat), 64'(EXP_LAT));
            check($sformatf("v%0d_pslverr", v), {63'd0, err}, {63'd0, vecs[v].exp_err});
            check($sformatf("v%0d_wr_pulse", v), {60'd0, pulse}, {60'd0, vecs[v].exp_pulse});
            check($sformatf("v%0d_reg%0d", v, vecs[v].chk_idx),
                  {32'd0, reg_q[vecs[v].chk_idx]}, {32'd0, vecs[v].exp_reg});
        end
        check("final_reg0", {32'd0, reg_q[0]}, {32'd0, 32'hCAFEF00D});
        check("final_reg1", {32'd0, reg_q[1]}, {32'd0, 32'h11BB33DD});
        check("final_reg2", {32'd0, reg_q[2]}, {32'd0, 32'hDEAD00EF});
        check("final_reg3", {32'd0, reg_q[3]}, {32'd0, 32'h01000000});

        // wr_pulse lasts exactly one cycle.
        xfer(12'h004, 32'h0000EE00, 4'b0010, 1'b1, lat, err, pulse);
        check("pulse1_first",  {60'd0, pulse}, {60'd0, 4'b0010});
        check("pulse1_reg1",   {32'd0, reg_q[1]}, {32'd0, 32'h11BBEEDD});
        @(negedge pclk);
        check("pulse1_cleared", {60'd0, wr_pulse}, 64'd0);

        // Stray enable in IDLE: no setup phase, so nothing must start.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr = 12'h000; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        for (int c = 0; c < 4; c++) begin
            @(negedge pclk);
            check($sformatf("stray_pready_c%0d", c), {63'd0, pready}, 64'd0);
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("stray_reg0", {32'd0, reg_q[0]}, {32'd0, 32'hCAFEF00D});
        xfer(12'h000, 32'h0, 4'h0, 1'b0, lat, err, pulse);
        check("stray_after_latency", 64'(lat), 64'(EXP_LAT));

`ifdef APB_WR_WAIT_EN
        // Abort: drop psel during the ACCESS wait states.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h000; pwdata = 32'h55555555; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        check("abort_wait_pready", {63'd0, pready}, 64'd0);
        psel = 1'b0; penable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge pclk);
            check($sformatf("abort_pready_c%0d", c), {63'd0, pready}, 64'd0);
            check($sformatf("abort_pulse_c%0d", c), {60'd0, wr_pulse}, 64'd0);
        end
        check("abort_reg0", {32'd0, reg_q[0]}, {32'd0, 32'hCAFEF00D});
        xfer(12'h000, 32'h0, 4'h0, 1'b0, lat, err, pulse);
        check("abort_after_latency", 64'(lat), 64'(EXP_LAT));
        check("abort_after_err", {63'd0, err}, 64'd0);
`endif

        // Reset asserted mid-write to 0x4 (SETUP state).
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h004; pwdata = 32'h99999999; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        presetn = 1'b0;
        #1;
        check("mid_rst_pready",   {63'd0, pready},   64'd0);
        check("mid_rst_pslverr",  {63'd0, pslverr},  64'd0);
        check("mid_rst_wr_pulse", {60'd0, wr_pulse}, 64'd0);
        for (int r = 0; r < 4; r++) check($sformatf("mid_rst_reg%0d", r), {32'd0, reg_q[r]}, 64'd0);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        presetn = 1'b1;
        repeat (EXP_LAT + 2) @(negedge pclk);
        check("post_rst_reg1",   {32'd0, reg_q[1]}, 64'd0);
        check("post_rst_pulse",  {60'd0, wr_pulse}, 64'd0);
        xfer(12'h00C, 32'hA5A5A5A5, 4'hF, 1'b1, lat, err, pulse);
        check("post_rst_latency", 64'(lat), 64'(EXP_LAT));
        check("post_rst_wpulse",  {60'd0, pulse}, {60'd0, 4'b1000});
        check("post_rst_reg3",    {32'd0, reg_q[3]}, {32'd0, 32'hA5A5A5A5});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_wr_demux.md
# apb_wr_demux

APB slave write-side register bank for the timer's register file. It decodes each APB write address to one of NUM_REGS word registers and commits the byte-strobed write data there, with a configurable number of wait states. Decode errors return a slave error. The stored registers are driven out in parallel so the read path can select among them.

## Interface

Parameters:
- NUM_REGS, 4, number of word registers.
- DATAWIDTH, 32, register and bus data width; must be a multiple of 8.
- ADDR_WIDTH, 12, paddr width.
- SEL_WIDTH, $clog2(NUM_REGS), register index width.
- WAIT_CYCLES, 2, wait states inserted per transfer when the wait feature is compiled in; 0 is legal.
- RESET_VAL, '0, reset value of every register.

Ports:
- pclk  in  1  clock; all logic is on the rising edge.
- presetn  in  1  reset; asynchronous assert, active-low.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATAWIDTH  write data.
- pstrb  in  DATAWIDTH/8  byte write strobes.
- pready  out  1  transfer completes this cycle.
- pslverr  out  1  decode error; valid only while pready=1.
- reg_q  out  [NUM_REGS][DATAWIDTH]  stored register contents.
- wr_pulse  out  NUM_REGS  one-hot; one-cycle pulse after a register is written.

## Operation

Address decode:
- OFS = $clog2(DATAWIDTH/8).
- Index = paddr[OFS+SEL_WIDTH-1:OFS].
- A decode error is any of:
  - paddr[OFS-1:0] != 0 (misaligned);
  - index >= NUM_REGS;
  - any paddr bit above OFS+SEL_WIDTH-1 nonzero.

FSM states are IDLE, SETUP and ACCESS.
- IDLE:
  - psel=1 and penable=0 -> SETUP.
  - penable=1 without a prior setup cycle is ignored; stay in IDLE.
- SETUP:
  - Latch paddr, pwrite, pwdata, pstrb and the decode result.
  - Load the wait counter with WAIT_CYCLES.
  - Go to ACCESS.
- ACCESS:
  - pready = (wcnt == 0).
  - While wcnt != 0, decrement wcnt each cycle.
  - On the cycle where pready=1, go to IDLE.
  - psel=0 in ACCESS aborts the transfer: go to IDLE, no write, no pready.
- Write commit happens on the rising edge where state=ACCESS, pready=1, latched pwrite=1 and no decode error.
  - For each byte b with pstrb[b]=1: reg_q[idx] byte b <= pwdata byte b.
  - Bytes whose strobe is 0 keep their value.
- An all-zero pstrb is a legal write: nothing is modified, but wr_pulse still fires.
- Read transfers (pwrite=0) complete with the same timing and the same pslverr rules and never modify reg_q.
- Decode error: pslverr=1 with pready; no register changes; no wr_pulse.

## Timing

- Transfer length is 2+WAIT_CYCLES cycles from the SETUP cycle to the pready cycle. With the wait feature compiled out it is 2 cycles.
- pready and pslverr are decoded from the registered state, with no combinational path from APB inputs.
- pslverr is 0 whenever pready is 0.
- reg_q shows the new value in the cycle after the commit edge.
- wr_pulse[idx] is high for exactly that one cycle.
- Back-to-back transfers:
  - A new SETUP presented in the cycle after pready is accepted from IDLE.
  - That gives a minimum of one IDLE cycle between accesses.
- Reset (presetn=0), at any time including mid-transfer:
  - state -> IDLE and wcnt -> 0;
  - reg_q -> RESET_VAL for every register;
  - wr_pulse -> 0, pready -> 0, pslverr -> 0;
  - an in-flight write is dropped.

## Configuration

- Macro APB_WR_WAIT_EN.
- Defined: the wait counter is present and WAIT_CYCLES wait states are inserted per transfer.
- Undefined:
  - the counter logic is removed and WAIT_CYCLES is ignored;
  - pready=1 in every ACCESS cycle (zero-wait APB).
- Decode, write and error behaviour are identical in both builds.

## Test plan

All scenarios use DATAWIDTH=32 and NUM_REGS=4.
- Reset: assert presetn=0 mid-write to 0x4 -> reg_q all equal RESET_VAL; pready=0; no wr_pulse.
- Full write: write 0x8, data 0xDEADBEEF, pstrb=4'hF, with APB_WR_WAIT_EN and WAIT_CYCLES=2 -> pready high in the 4th cycle; reg_q[2]=0xDEADBEEF next cycle; wr_pulse=4'b0100 for 1 cycle.
- Strobed write: reg_q[1]=0x11223344, then write 0x4 data 0xAABBCCDD with pstrb=4'b0101 -> reg_q[1]=0x11BB33DD.
- Decode error: write to 0x10, and separately to 0x6 -> pslverr=1 with pready; reg_q unchanged; no wr_pulse.
- Abort and stray enable: drop psel in the ACCESS wait -> no write and FSM returns to IDLE; penable=1 in IDLE -> ignored.
- Zero-wait build: APB_WR_WAIT_EN undefined, back-to-back writes to 0x0 then 0xC -> each completes in 2 cycles; both registers updated; read to 0x0 -> pready, pslverr=0, reg_q unchanged.
